// File: rtl/booth_mul_sched.sv
// Round-robin front end that shares one sequential Booth core between two requesters.
// Accept->mul_start next cycle, done->rsp_valid next cycle; responses hold until rsp_ready.
module booth_mul_sched #(
    parameter int WIDTH   = 16,
    parameter int CW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [WIDTH-1:0]     req_a0,
    input  logic [WIDTH-1:0]     req_b0,
    input  logic [WIDTH-1:0]     req_a1,
    input  logic [WIDTH-1:0]     req_b1,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic [CW-1:0]        mul_add_ops,
    input  logic [CW-1:0]        mul_sub_ops,
    input  logic                 mul_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic [CW-1:0]        rsp_add_ops,
    output logic [CW-1:0]        rsp_sub_ops,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int              TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   CNT_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ptr;
    logic [TW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_mul_a;
    logic [WIDTH-1:0]    r_mul_b;
    logic                r_rsp_id;
    logic [2*WIDTH-1:0]  r_rsp_product;
    logic [CW-1:0]       r_rsp_add;
    logic [CW-1:0]       r_rsp_sub;
    logic                r_rsp_err;

    logic                w_any_vld;
    logic                w_grant;
    logic                w_timeout;
    logic [1:0]          w_req_ready;

    assign w_any_vld = |req_valid;
    // Pointer's requester wins when valid; otherwise the other one gets the slot.
    assign w_grant   = req_valid[r_ptr] ? r_ptr : ~r_ptr;
    assign w_timeout = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_any_vld) begin
                    w_state_nxt = S_ISSUE;
                    if (rst_n) begin
                        w_req_ready = w_grant ? 2'b10 : 2'b01;
                    end
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (mul_done || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= 1'b0;
            r_cnt         <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_rsp_id      <= 1'b0;
            r_rsp_product <= '0;
            r_rsp_add     <= '0;
            r_rsp_sub     <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_vld) begin
                        r_mul_a  <= w_grant ? req_a1 : req_a0;
                        r_mul_b  <= w_grant ? req_b1 : req_b0;
                        r_rsp_id <= w_grant;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A done arriving on the last allowed cycle still counts as success.
                    if (mul_done) begin
                        r_rsp_product <= mul_product;
                        r_rsp_add     <= mul_add_ops;
                        r_rsp_sub     <= mul_sub_ops;
                        r_rsp_err     <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_product <= '0;
                        r_rsp_add     <= '0;
                        r_rsp_sub     <= '0;
                        r_rsp_err     <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_ptr <= ~r_rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign mul_start   = (r_state == S_ISSUE);
    assign rsp_valid   = (r_state == S_RESP);
    assign busy        = (r_state != S_IDLE);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;
    assign rsp_add_ops = r_rsp_add;
    assign rsp_sub_ops = r_rsp_sub;
    assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched; the bench plays the Booth core and both clients.
module tb_booth_mul_sched;
    localparam int W  = 16;
    localparam int CW = 5;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [W-1:0]    req_a0, req_b0, req_a1, req_b1;
    logic            mul_start;
    logic [W-1:0]    mul_a, mul_b;
    logic [2*W-1:0]  mul_product;
    logic [CW-1:0]   mul_add_ops, mul_sub_ops;
    logic            mul_done;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [2*W-1:0]  rsp_product;
    logic [CW-1:0]   rsp_add_ops, rsp_sub_ops;

    int n_cmp  = 0;
    int n_fail = 0;
    int both_hi = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (req_ready == 2'b11) both_hi++;

    booth_mul_sched #(.WIDTH(W), .CW(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_add_ops(mul_add_ops), .mul_sub_ops(mul_sub_ops),
        .mul_done(mul_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_add_ops(rsp_add_ops), .rsp_sub_ops(rsp_sub_ops),
        .rsp_err(rsp_err), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mul_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Core model: done pulse lat cycles after the observed start cycle, then garbage on the bus.
    task automatic core_done(input int lat, input logic [2*W-1:0] prod,
                             input logic [CW-1:0] add, input logic [CW-1:0] sub);
        repeat (lat) tick();
        mul_done = 1'b1; mul_product = prod; mul_add_ops = add; mul_sub_ops = sub;
        tick();
        mul_done = 1'b0; mul_product = 32'hBADC0DE5; mul_add_ops = 5'h1F; mul_sub_ops = 5'h1E;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 2'b01;
        tick();
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready got=%b want=00", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        n_cmp++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL rst_mul_start got=%b want=0", mul_start); end
        n_cmp++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin n_fail++; $display("FAIL rst_mul_ab got=%h/%h want=0/0", mul_a, mul_b); end
        n_cmp++; if ({rsp_id, rsp_err, rsp_product, rsp_add_ops, rsp_sub_ops} !== '0) begin
            n_fail++; $display("FAIL rst_rsp_fields got=%b/%b/%h/%h/%h want=all 0", rsp_id, rsp_err, rsp_product, rsp_add_ops, rsp_sub_ops); end
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        req_valid = 2'b01; req_a0 = 16'd3; req_b0 = 16'd5; rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL t1_req_ready got=%b want=01", req_ready); end
        n_cmp++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL t1_start_early got=%b want=0", mul_start); end
        tick();
        req_valid = 2'b00;
        n_cmp++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL t1_start_latency got=%b want=1", mul_start); end
        n_cmp++; if (mul_a !== 16'd3 || mul_b !== 16'd5) begin n_fail++; $display("FAIL t1_operands got=%h/%h want=3/5", mul_a, mul_b); end
        repeat (4) tick();
        n_cmp++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL t1_start_pulse got=%b want=0", mul_start); end
        mul_done = 1'b1; mul_product = 32'd15; mul_add_ops = 5'd1; mul_sub_ops = 5'd1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_rsp_early got=%b want=0", rsp_valid); end
        tick();
        mul_done = 1'b0; mul_product = '0; mul_add_ops = '0; mul_sub_ops = '0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL t1_rsp_latency got=%b want=1", rsp_valid); end
        n_cmp++; if ({rsp_id, rsp_err} !== 2'b00) begin n_fail++; $display("FAIL t1_id_err got=%b%b want=00", rsp_id, rsp_err); end
        n_cmp++; if (rsp_product !== 32'd15) begin n_fail++; $display("FAIL t1_product got=%h want=f", rsp_product); end
        n_cmp++; if (rsp_add_ops !== 5'd1 || rsp_sub_ops !== 5'd1) begin n_fail++; $display("FAIL t1_counts got=%h/%h want=1/1", rsp_add_ops, rsp_sub_ops); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t1_after_hs got=%b/%b want=0/0", rsp_valid, busy); end
    endtask

    task automatic test_fairness;
        bit ok;
        int hi0;
        logic exp_id;
        hi0 = both_hi;
        rst_n = 1'b0;
        req_valid = 2'b11; req_a0 = 16'h0011; req_b0 = 16'h0001; req_a1 = 16'h0022; req_b1 = 16'h0002;
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = i[0];
            wait_start(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL t2_start_timeout got=no start want=start txn %0d", i); end
            n_cmp++; if (mul_a !== (exp_id ? 16'h0022 : 16'h0011)) begin n_fail++; $display("FAIL t2_operand txn %0d got=%h want=%h", i, mul_a, exp_id ? 16'h0022 : 16'h0011); end
            core_done(2, 32'(i + 100), 5'd2, 5'd0);
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id) begin n_fail++; $display("FAIL t2_order txn %0d got=v%b id%b want=v1 id%b", i, rsp_valid, rsp_id, exp_id); end
            n_cmp++; if (rsp_product !== 32'(i + 100)) begin n_fail++; $display("FAIL t2_product txn %0d got=%h want=%h", i, rsp_product, 32'(i + 100)); end
            tick();
        end
        req_valid = 2'b00;
        tick();
        n_cmp++; if (both_hi - hi0 !== 0) begin n_fail++; $display("FAIL t2_ready_onehot got=%0d cycles with 11 want=0", both_hi - hi0); end
    endtask

    task automatic test_backpressure;
        bit ok;
        req_valid = 2'b01; req_a0 = 16'd7; req_b0 = 16'd6; rsp_ready = 1'b0;
        tick();
        req_valid = 2'b10; req_a1 = 16'd9; req_b1 = 16'd9;
        wait_start(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL t3_start_timeout got=no start want=start"); end
        core_done(2, 32'd42, 5'd2, 5'd1);
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
                n_fail++; $display("FAIL t3_hold_ctl cyc %0d got=v%b id%b e%b want=v1 id0 e0", c, rsp_valid, rsp_id, rsp_err); end
            n_cmp++; if (rsp_product !== 32'd42 || rsp_add_ops !== 5'd2 || rsp_sub_ops !== 5'd1) begin
                n_fail++; $display("FAIL t3_hold_data cyc %0d got=%h/%h/%h want=2a/2/1", c, rsp_product, rsp_add_ops, rsp_sub_ops); end
            n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL t3_ready_in_resp cyc %0d got=%b want=00", c, req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL t3_ready_hs_cycle got=%b want=00", req_ready); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || mul_start !== 1'b0) begin n_fail++; $display("FAIL t3_after_hs got=v%b s%b want=v0 s0", rsp_valid, mul_start); end
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL t3_req1_ready got=%b want=10", req_ready); end
        tick();
        req_valid = 2'b00;
        n_cmp++; if (mul_start !== 1'b1 || mul_a !== 16'd9 || rsp_id !== 1'b1) begin
            n_fail++; $display("FAIL t3_req1_accept got=s%b a%h id%b want=s1 a9 id1", mul_start, mul_a, rsp_id); end
        core_done(1, 32'd81, 5'd1, 5'd0);
        n_cmp++; if (rsp_product !== 32'd81) begin n_fail++; $display("FAIL t3_req1_product got=%h want=51", rsp_product); end
        tick();
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        req_valid = 2'b01; req_a0 = 16'd4; req_b0 = 16'd4; rsp_ready = 1'b0;
        mul_product = 32'hCAFEF00D; mul_add_ops = 5'd3; mul_sub_ops = 5'd3;
        tick();
        req_valid = 2'b00;
        wait_start(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL t4_start_timeout got=no start want=start"); end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== TO + 1) begin n_fail++; $display("FAIL t4_timeout_cycles got=%0d want=%0d", n, TO + 1); end
        n_cmp++; if (rsp_err !== 1'b1 || rsp_product !== 32'd0) begin n_fail++; $display("FAIL t4_err_rsp got=e%b p%h want=e1 p0", rsp_err, rsp_product); end
        n_cmp++; if (rsp_add_ops !== 5'd0 || rsp_sub_ops !== 5'd0) begin n_fail++; $display("FAIL t4_err_counts got=%h/%h want=0/0", rsp_add_ops, rsp_sub_ops); end
        rsp_ready = 1'b1;
        tick();
        mul_done = 1'b1; mul_product = 32'h00001234;
        tick();
        mul_done = 1'b0;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || mul_start !== 1'b0) begin
            n_fail++; $display("FAIL t4_stray_done got=b%b v%b s%b want=b0 v0 s0", busy, rsp_valid, mul_start); end
        tick();
        n_cmp++; if (busy !== 1'b0 || rsp_product !== 32'd0) begin n_fail++; $display("FAIL t4_stray_late got=b%b p%h want=b0 p0", busy, rsp_product); end
    endtask

    task automatic test_reset_mid_op;
        bit ok;
        req_valid = 2'b01; req_a0 = 16'd5; req_b0 = 16'd5; rsp_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t5_busy_in_wait got=%b want=1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || mul_start !== 1'b0) begin
            n_fail++; $display("FAIL t5_async_reset got=b%b v%b s%b want=b0 v0 s0", busy, rsp_valid, mul_start); end
        n_cmp++; if (mul_a !== 16'd0) begin n_fail++; $display("FAIL t5_mul_a_reset got=%h want=0", mul_a); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t5_no_aborted_rsp got=%b want=0", rsp_valid); end
        req_valid = 2'b01; req_a0 = 16'd2; req_b0 = 16'd2;
        tick();
        req_valid = 2'b00;
        wait_start(ok);
        n_cmp++; if (!ok || mul_a !== 16'd2) begin n_fail++; $display("FAIL t5_restart got=ok%b a%h want=ok1 a2", ok, mul_a); end
        core_done(3, 32'd4, 5'd0, 5'd1);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_product !== 32'd4 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL t5_rsp got=v%b p%h id%b e%b want=v1 p4 id0 e0", rsp_valid, rsp_product, rsp_id, rsp_err); end
        tick();
    endtask

    task automatic test_raw_bits;
        req_valid = 2'b10; req_a1 = 16'hFFFE; req_b1 = 16'h0003; rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL t6_req_ready got=%b want=10", req_ready); end
        tick();
        req_valid = 2'b00;
        n_cmp++; if (mul_start !== 1'b1 || mul_a !== 16'hFFFE || mul_b !== 16'h0003) begin
            n_fail++; $display("FAIL t6_operands got=s%b %h/%h want=s1 fffe/0003", mul_start, mul_a, mul_b); end
        core_done(2, 32'hFFFFFFFA, 5'd1, 5'd1);
        n_cmp++; if (rsp_product !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL t6_product got=%h want=fffffffa", rsp_product); end
        n_cmp++; if (rsp_id !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL t6_id_err got=id%b e%b want=id1 e0", rsp_id, rsp_err); end
        n_cmp++; if (rsp_add_ops !== 5'd1 || rsp_sub_ops !== 5'd1) begin n_fail++; $display("FAIL t6_counts got=%h/%h want=1/1", rsp_add_ops, rsp_sub_ops); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        mul_product = '0; mul_add_ops = '0; mul_sub_ops = '0; mul_done = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_reset_mid_op();
        test_raw_bits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Round-robin scheduler that shares one sequential Booth multiplier core between two requesters.
- Accepts operand pairs over valid/ready and issues a one-cycle start pulse to the core.
- Waits for the core's done pulse, guarded by a timeout, then returns the product and add/sub op counts with the requester ID over a valid/ready response channel.
- Sits between client logic and the existing booth datapath; the core itself is not modified.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH.
- CW, 5, width of add/sub op-count fields.
- TIMEOUT, 64, maximum WAIT cycles before an error response; must be ≥2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; at most one bit high
- req_a0, req_b0  in  WIDTH each  requester 0 multiplicand, multiplier
- req_a1, req_b1  in  WIDTH each  requester 1 multiplicand, multiplier
- mul_start  out  1  one-cycle start pulse to the core
- mul_a, mul_b  out  WIDTH each  operands to the core
- mul_product  in  2*WIDTH  core result
- mul_add_ops, mul_sub_ops  in  CW each  core op counts
- mul_done  in  1  core done pulse
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester served
- rsp_product  out  2*WIDTH  result
- rsp_add_ops, rsp_sub_ops  out  CW each  op counts
- rsp_err  out  1  timeout flag
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state=IDLE; priority pointer=0.
  - All registered outputs 0: mul_start, mul_a, mul_b, rsp_*, busy.
  - req_ready=0 while rst_n is low.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the pointer's requester if its req_valid is high, else to the other requester if its req_valid is high.
  - req_ready[grant] is driven combinationally in IDLE only.
  - Transfer occurs on the edge where valid&ready. That edge latches the operands into mul_a/mul_b and the ID into rsp_id, then moves to ISSUE.
  - No valid request: remain in IDLE.
- ISSUE (exactly 1 cycle):
  - mul_start=1; WAIT counter cleared; next state WAIT.
  - mul_done in ISSUE is ignored; the core must assert done ≥1 cycle after start.
- WAIT:
  - Counter increments each cycle.
  - On mul_done=1: capture mul_product/add/sub into rsp_*, rsp_err=0, go to RESP.
  - If the counter reaches TIMEOUT-1 with no done: rsp_product=0, counts=0, rsp_err=1, go to RESP.
  - If done and timeout coincide, done wins (err=0).
- RESP:
  - rsp_valid=1; all rsp_* stay stable until rsp_ready.
  - On the handshake edge: rsp_valid→0, pointer = ~rsp_id, state→IDLE.
  - No new request is accepted in the handshake cycle.
- Latency: accept edge → mul_start high next cycle. Core done edge → rsp_valid high next cycle.
- mul_a/mul_b hold their values from acceptance until the next acceptance.
- mul_done seen in IDLE or RESP is ignored. This covers stray pulses after a timeout or a reset.
- Reset mid-operation aborts the transaction; no response is produced for it.
- Operands and product are passed as raw bits; no sign handling in the scheduler.
- Fairness: with both requesters continuously valid, service strictly alternates.

Test Plan:
1. Reset, then req0 a=3 b=5; core asserts done 4 cycles after start with product=15, add=1, sub=1, rsp_ready=1.
   → mul_start exactly 1 cycle after accept; rsp_valid 1 cycle after done; rsp_id=0, product=15, add=1, sub=1, err=0.
2. Both req_valid held high from reset, four transactions, core done latency 2.
   → service order 0,1,0,1; req_ready never has both bits high.
3. rsp_ready held low 3 cycles in RESP with req1 valid.
   → rsp_valid and all rsp_* stable for 3 cycles; req_ready=0 throughout; req1 accepted only after the response handshake.
4. TIMEOUT=8, core never asserts done.
   → rsp_valid after 8 WAIT cycles with err=1, product=0; a later stray mul_done in IDLE has no effect.
5. rst_n low for one cycle in WAIT.
   → busy, rsp_valid and mul_start go to 0 immediately; the next req0 a=2 b=2 (done→4) returns product=4 normally.
6. req1 a=0xFFFE b=0x0003; core returns 0xFFFFFFFA, add=1, sub=1.
   → rsp_product=0xFFFFFFFA, rsp_id=1, counts passed unchanged.
